two_byte_serializer: RTL and testbench



---
 rtl/two_byte_serializer_pkg.sv | 13 +
 rtl/two_byte_serializer_if.sv | 25 ++
 rtl/two_byte_serializer.sv | 138 +++++++++++++
 tb/tb_two_byte_serializer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/two_byte_serializer_pkg.sv
// Shared widths and FSM encodings for the 16-bit word to byte-stream serializer.
package two_byte_serializer_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

endpackage

// File: rtl/two_byte_serializer_if.sv
// Word-in / byte-out valid-ready bus; slave is the serializer side, master drives it.
interface two_byte_serializer_if #(
    parameter int WORD_W = two_byte_serializer_pkg::WORD_W,
    parameter int BYTE_W = two_byte_serializer_pkg::BYTE_W
);

    logic [WORD_W-1:0] d;
    logic              d_valid;
    logic              d_ready;
    logic [BYTE_W-1:0] q;
    logic              q_valid;
    logic              q_ready;
    logic              q_last;

    modport slave (
        input  d, d_valid, q_ready,
        output d_ready, q, q_valid, q_last
    );

    modport master (
        output d, d_valid, q_ready,
        input  d_ready, q, q_valid, q_last
    );

endinterface

// File: rtl/two_byte_serializer.sv
// Accepts one word per handshake and emits it as two bytes, supporting back-to-back words.
module two_byte_serializer #(
    parameter int WORD_W    = two_byte_serializer_pkg::WORD_W,
    parameter int BYTE_W    = two_byte_serializer_pkg::BYTE_W,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        en,
    two_byte_serializer_if.slave        bus,
    output logic [CNT_W-1:0]            words_sent
);

    import two_byte_serializer_pkg::*;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [WORD_W-1:0]   word_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                d_ready_s;
    logic                q_valid_s;
    logic                q_last_s;
    logic [BYTE_W-1:0]   q_s;
    logic                accept_s;
    logic                xfer_s;
    logic                load_s;
    logic                done_s;
    logic [BYTE_W-1:0]   lo_byte_s;
    logic [BYTE_W-1:0]   hi_byte_s;

    // Handshake qualifiers; en low forces both ready and valid low, which freezes everything.
    always_comb begin
        d_ready_s = en & res & ((state_r == ST_IDLE) |
                                ((state_r == ST_SECOND) & bus.q_ready));
        q_valid_s = en & (state_r != ST_IDLE);
        accept_s  = bus.d_valid & d_ready_s;
        xfer_s    = q_valid_s & bus.q_ready;
    end

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic plus word-load and word-done strobes
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_FIRST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FIRST: begin
                if (xfer_s) begin
                    state_nxt_s = ST_SECOND;
                end else begin
                    state_nxt_s = ST_FIRST;
                end
            end
            ST_SECOND: begin
                if (xfer_s) begin
                    done_s = 1'b1;
                    // A new word may be taken in the same cycle the last byte leaves.
                    if (accept_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_FIRST;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_SECOND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Holding register and completed-word counter
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            word_r <= {WORD_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (load_s) begin
                word_r <= bus.d;
            end
            if (done_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Output byte selection by state and byte order
    always_comb begin
        lo_byte_s = word_r[BYTE_W-1:0];
        hi_byte_s = word_r[WORD_W-1 -: BYTE_W];
        q_last_s  = (state_r == ST_SECOND);
        case (state_r)
            ST_FIRST: begin
                if (LSB_FIRST != 0) begin
                    q_s = lo_byte_s;
                end else begin
                    q_s = hi_byte_s;
                end
            end
            ST_SECOND: begin
                if (LSB_FIRST != 0) begin
                    q_s = hi_byte_s;
                end else begin
                    q_s = lo_byte_s;
                end
            end
            default: begin
                q_s = {BYTE_W{1'b0}};
            end
        endcase
    end

    assign bus.d_ready = d_ready_s;
    assign bus.q_valid = q_valid_s;
    assign bus.q_last  = q_last_s;
    assign bus.q       = q_s;
    assign words_sent  = cnt_r;

endmodule

// File: tb/tb_two_byte_serializer.sv
// Bench for two_byte_serializer: directed vector table, reset/wrap sequences, random run vs queue model.
module tb_two_byte_serializer;

    logic       clk;
    logic       res;
    logic       en;
    logic [7:0] ws_l;
    logic [7:0] ws_m;

    int errors = 0;
    int checks = 0;

    two_byte_serializer_if #(.WORD_W(16), .BYTE_W(8)) if_l ();
    two_byte_serializer_if #(.WORD_W(16), .BYTE_W(8)) if_m ();

    two_byte_serializer #(.WORD_W(16), .BYTE_W(8), .LSB_FIRST(1), .CNT_W(8)) u_lsb (
        .clk(clk), .res(res), .en(en), .bus(if_l), .words_sent(ws_l)
    );

    two_byte_serializer #(.WORD_W(16), .BYTE_W(8), .LSB_FIRST(0), .CNT_W(8)) u_msb (
        .clk(clk), .res(res), .en(en), .bus(if_m), .words_sent(ws_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        dv;
        logic [15:0] d;
        logic        qr;
        logic        dr;
        logic        qv;
        logic [7:0]  ql;
        logic [7:0]  qm;
        logic        last;
        logic [7:0]  ws;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic dv, input logic [15:0] d, input logic qr);
        en = e;
        if_l.d_valid = dv; if_l.d = d; if_l.q_ready = qr;
        if_m.d_valid = dv; if_m.d = d; if_m.q_ready = qr;
    endtask

    task automatic chk_all(input string tag, input logic dr, input logic qv, input logic [7:0] ql,
                           input logic [7:0] qm, input logic last, input logic [7:0] ws);
        chk({tag, ".d_ready_l"}, {31'd0, if_l.d_ready}, {31'd0, dr});
        chk({tag, ".d_ready_m"}, {31'd0, if_m.d_ready}, {31'd0, dr});
        chk({tag, ".q_valid_l"}, {31'd0, if_l.q_valid}, {31'd0, qv});
        chk({tag, ".q_valid_m"}, {31'd0, if_m.q_valid}, {31'd0, qv});
        chk({tag, ".q_l"}, {24'd0, if_l.q}, {24'd0, ql});
        chk({tag, ".q_m"}, {24'd0, if_m.q}, {24'd0, qm});
        chk({tag, ".q_last_l"}, {31'd0, if_l.q_last}, {31'd0, last});
        chk({tag, ".q_last_m"}, {31'd0, if_m.q_last}, {31'd0, last});
        chk({tag, ".ws_l"}, {24'd0, ws_l}, {24'd0, ws});
        chk({tag, ".ws_m"}, {24'd0, ws_m}, {24'd0, ws});
    endtask

    task automatic add(input logic e, input logic dv, input logic [15:0] d, input logic qr,
                       input logic dr, input logic qv, input logic [7:0] ql, input logic [7:0] qm,
                       input logic last, input logic [7:0] ws);
        vec_t v;
        v.en = e; v.dv = dv; v.d = d; v.qr = qr;
        v.dr = dr; v.qv = qv; v.ql = ql; v.qm = qm; v.last = last; v.ws = ws;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        res = 1'b1;
    endtask

    initial begin
        logic [7:0] mq_l[$];
        logic [7:0] mq_m[$];
        logic [7:0] m_ws;
        logic       e, dv, qr, x_dr, x_qv, xf, ac;
        logic [15:0] d;
        logic [7:0] x_ql, x_qm;

        // Reset held with a valid word offered: nothing may happen.
        res = 1'b0;
        drive(1'b1, 1'b1, 16'hF00F, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk_all("reset", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0);
        end

        // en dv d qr | d_ready q_valid q_lsb q_msb q_last words_sent
        add(1, 1, 16'hF00F, 1, 1, 0, 8'h00, 8'h00, 0, 8'd0);
        add(1, 0, 16'h0000, 1, 0, 1, 8'h0F, 8'hF0, 0, 8'd0);
        add(1, 0, 16'h0000, 1, 1, 1, 8'hF0, 8'h0F, 1, 8'd0);
        add(1, 1, 16'h0FAA, 1, 1, 0, 8'h00, 8'h00, 0, 8'd1);
        add(1, 0, 16'h0000, 1, 0, 1, 8'hAA, 8'h0F, 0, 8'd1);
        add(1, 1, 16'hF0AA, 1, 1, 1, 8'h0F, 8'hAA, 1, 8'd1);
        add(1, 0, 16'h0000, 1, 0, 1, 8'hAA, 8'hF0, 0, 8'd2);
        add(1, 0, 16'h0000, 1, 1, 1, 8'hF0, 8'hAA, 1, 8'd2);
        add(1, 1, 16'h1234, 1, 1, 0, 8'h00, 8'h00, 0, 8'd3);
        add(1, 1, 16'h5555, 0, 0, 1, 8'h34, 8'h12, 0, 8'd3);
        add(1, 1, 16'h5555, 0, 0, 1, 8'h34, 8'h12, 0, 8'd3);
        add(1, 1, 16'h5555, 0, 0, 1, 8'h34, 8'h12, 0, 8'd3);
        add(1, 0, 16'h0000, 1, 0, 1, 8'h34, 8'h12, 0, 8'd3);
        add(1, 0, 16'h0000, 1, 1, 1, 8'h12, 8'h34, 1, 8'd3);
        add(1, 1, 16'hABCD, 1, 1, 0, 8'h00, 8'h00, 0, 8'd4);
        add(1, 0, 16'h0000, 1, 0, 1, 8'hCD, 8'hAB, 0, 8'd4);
        add(1, 1, 16'h9999, 0, 0, 1, 8'hAB, 8'hCD, 1, 8'd4);
        add(0, 1, 16'h9999, 1, 0, 0, 8'hAB, 8'hCD, 1, 8'd4);
        add(0, 1, 16'h9999, 1, 0, 0, 8'hAB, 8'hCD, 1, 8'd4);
        add(1, 0, 16'h0000, 1, 1, 1, 8'hAB, 8'hCD, 1, 8'd4);
        add(1, 0, 16'h0000, 0, 1, 0, 8'h00, 8'h00, 0, 8'd5);

        foreach (vq[i]) begin
            @(negedge clk);
            res = 1'b1;
            drive(vq[i].en, vq[i].dv, vq[i].d, vq[i].qr);
            #1 chk_all($sformatf("vec%0d", i), vq[i].dr, vq[i].qv, vq[i].ql, vq[i].qm,
                       vq[i].last, vq[i].ws);
        end

        // Reset asserted while the second byte is pending.
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h1357, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        #1 chk_all("mid_second", 1'b0, 1'b1, 8'h13, 8'h57, 1'b1, 8'd5);
        res = 1'b0;
        #1 chk_all("mid_reset", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0);
        @(negedge clk);
        res = 1'b1;
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        #1 chk_all("post_reset", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0);

        // Random traffic against a byte-queue model.
        m_ws = 8'd0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            e  = ($urandom_range(0, 9) != 0);
            dv = $urandom_range(0, 1);
            qr = ($urandom_range(0, 3) != 0);
            d  = 16'($urandom);
            drive(e, dv, d, qr);
            x_dr = e && (mq_l.size() == 0 || (mq_l.size() == 1 && qr));
            x_qv = e && (mq_l.size() != 0);
            x_ql = (mq_l.size() != 0) ? mq_l[0] : 8'h00;
            x_qm = (mq_m.size() != 0) ? mq_m[0] : 8'h00;
            #1 chk_all("rand", x_dr, x_qv, x_ql, x_qm, (mq_l.size() == 1), m_ws);
            xf = x_qv && qr;
            ac = dv && x_dr;
            if (xf) begin
                void'(mq_l.pop_front());
                void'(mq_m.pop_front());
                if (mq_l.size() == 0) m_ws = m_ws + 8'd1;
            end
            if (ac) begin
                mq_l.push_back(d[7:0]);  mq_l.push_back(d[15:8]);
                mq_m.push_back(d[15:8]); mq_m.push_back(d[7:0]);
            end
        end

        // Counter wrap: 256 back-to-back words from reset.
        do_reset();
        drive(1'b1, 1'b1, 16'hC3A5, 1'b1);
        for (int c = 0; c < 1 + 2 * 255; c++) @(negedge clk);
        #1 chk("ws_255_l", {24'd0, ws_l}, 32'd255);
        chk("ws_255_m", {24'd0, ws_m}, 32'd255);
        for (int c = 0; c < 2; c++) @(negedge clk);
        #1 chk("ws_wrap_l", {24'd0, ws_l}, 32'd0);
        chk("ws_wrap_m", {24'd0, ws_m}, 32'd0);
        chk("wrap_q_l", {24'd0, if_l.q}, 32'h0000_00A5);
        chk("wrap_q_m", {24'd0, if_m.q}, 32'h0000_00C3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
